// File: rtl/midi_voice_ctrl_if.sv
// Byte handshake between the MIDI UART receiver (master) and the voice controller (slave).
interface midi_voice_ctrl_if;
  logic [7:0] midi_byte;
  logic       midi_byte_valid;
  logic       midi_byte_ready;

  modport master (output midi_byte, output midi_byte_valid, input midi_byte_ready);
  modport slave  (input midi_byte, input midi_byte_valid, output midi_byte_ready);
endinterface

// File: rtl/midi_voice_ctrl.sv
// MIDI channel-message parser producing divider/waveform update strobes for the voice NCO block.
// Build macro MIDI_NOTE_MATCH_EN: Note Off acts only when it matches the voice's held note.
//
// state | meaning
// IDLE  | waiting for status, or data1 under running status
// DATA1 | status seen, waiting for data1
// DATA2 | waiting for data2
// CALC  | reducing note to (semitone, octave), one step per cycle
// EMIT  | one-cycle strobe of the latched update
module midi_voice_ctrl #(
  parameter int D_W        = 16,
  parameter int VOICE_BITS = 2,
  parameter int NUM_VOICES = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  midi_voice_ctrl_if.slave      midi_in,
  output logic [VOICE_BITS-1:0] midi_modified_channel,
  output logic [D_W-1:0]        midi_modified_divider,
  output logic                  midi_chan_modified_strobe,
  output logic [1:0]            wave_input,
  output logic                  midi_wave_modified_strobe
);
  typedef enum logic [2:0] {IDLE, DATA1, DATA2, CALC, EMIT} state_t;
  state_t state, state_nx;

  logic [7:0]            run_status;
  logic                  run_valid;
  logic [6:0]            data1_q;
  logic [6:0]            rem;
  logic [3:0]            oct;
  logic [VOICE_BITS-1:0] voice_q;
  logic                  emit_wave;

  // 187500 / f(note) for the lowest octave; higher octaves are right shifts.
  function automatic logic [14:0] base_div(input logic [3:0] idx);
    case (idx)
      4'd0:    base_div = 15'd22933;
      4'd1:    base_div = 15'd21646;
      4'd2:    base_div = 15'd20431;
      4'd3:    base_div = 15'd19285;
      4'd4:    base_div = 15'd18202;
      4'd5:    base_div = 15'd17181;
      4'd6:    base_div = 15'd16217;
      4'd7:    base_div = 15'd15306;
      4'd8:    base_div = 15'd14447;
      4'd9:    base_div = 15'd13636;
      4'd10:   base_div = 15'd12871;
      4'd11:   base_div = 15'd12149;
      default: base_div = 15'd0;
    endcase
  endfunction

  logic [7:0]            byte_in;
  logic                  byte_fire, is_rt, is_sys, is_status, is_data;
  logic [3:0]            cmd, chan_n;
  logic                  two_byte, msg_done, voice_ok, off_ok;
  logic [6:0]            d1, d2;
  logic [VOICE_BITS-1:0] voice;
  logic                  act_on, act_off, act_pc;

  assign byte_in   = midi_in.midi_byte;
  assign byte_fire = midi_in.midi_byte_valid && midi_in.midi_byte_ready;
  assign is_rt     = byte_in[7:3] == 5'b11111;
  assign is_sys    = byte_in[7:3] == 5'b11110;
  assign is_status = byte_in[7] && (byte_in[7:4] != 4'hF);
  assign is_data   = !byte_in[7];
  assign cmd       = run_status[7:4];
  assign chan_n    = run_status[3:0];
  assign two_byte  = (cmd != 4'hC) && (cmd != 4'hD);
  assign msg_done  = byte_fire && is_data &&
                     ((state == DATA2) ||
                      (!two_byte && ((state == DATA1) || (state == IDLE && run_valid))));
  assign d1        = (state == DATA2) ? data1_q : byte_in[6:0];
  assign d2        = byte_in[6:0];
  assign voice     = chan_n[VOICE_BITS-1:0];
  assign voice_ok  = int'(chan_n) < NUM_VOICES;
  assign act_on    = msg_done && voice_ok && (cmd == 4'h9) && (d2 != 7'd0);
  assign act_off   = msg_done && voice_ok && off_ok &&
                     ((cmd == 4'h8) || ((cmd == 4'h9) && (d2 == 7'd0)));
  assign act_pc    = msg_done && voice_ok && (cmd == 4'hC);

`ifdef MIDI_NOTE_MATCH_EN
  logic [6:0]            note_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] note_vld;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      note_vld <= '0;
      for (int i = 0; i < NUM_VOICES; i++) note_q[i] <= '0;
    end else if (act_on) begin
      note_q[voice]   <= d1;
      note_vld[voice] <= 1'b1;
    end else if (act_off) begin
      note_vld[voice] <= 1'b0;
    end
  end

  assign off_ok = note_vld[voice] && (note_q[voice] == d1);
`else
  assign off_ok = 1'b1;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DATA1, DATA2: begin
        if (byte_fire && !is_rt) begin
          if (is_sys)                          state_nx = IDLE;
          else if (is_status)                  state_nx = DATA1;
          else if (state == IDLE && !run_valid) state_nx = IDLE;
          else if (act_on)                     state_nx = CALC;
          else if (act_off || act_pc)          state_nx = EMIT;
          else if (msg_done)                   state_nx = IDLE;
          else                                 state_nx = DATA2;
        end
      end
      CALC:    if (rem < 7'd12) state_nx = EMIT;
      EMIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    midi_in.midi_byte_ready   = (state == IDLE) || (state == DATA1) || (state == DATA2);
    midi_chan_modified_strobe = (state == EMIT) && !emit_wave;
    midi_wave_modified_strobe = (state == EMIT) && emit_wave;
  end

  // Outputs load on the edge into EMIT so they are valid alongside the strobe.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      run_status            <= '0;
      run_valid             <= 1'b0;
      data1_q               <= '0;
      rem                   <= '0;
      oct                   <= '0;
      voice_q               <= '0;
      emit_wave             <= 1'b0;
      midi_modified_channel <= '0;
      midi_modified_divider <= '0;
      wave_input            <= '0;
    end else begin
      if (byte_fire && !is_rt) begin
        if (is_sys) begin
          run_valid <= 1'b0;
        end else if (is_status) begin
          run_status <= byte_in;
          run_valid  <= 1'b1;
        end else if (state != DATA2) begin
          data1_q <= byte_in[6:0];
        end
      end
      if (act_on) begin
        rem     <= d1;
        oct     <= '0;
        voice_q <= voice;
      end
      if (act_off) begin
        midi_modified_channel <= voice;
        midi_modified_divider <= '0;
        emit_wave             <= 1'b0;
      end
      if (act_pc) begin
        midi_modified_channel <= voice;
        wave_input            <= d1[1:0];
        emit_wave             <= 1'b1;
      end
      if (state == CALC) begin
        if (rem >= 7'd12) begin
          rem <= rem - 7'd12;
          oct <= oct + 4'd1;
        end else begin
          midi_modified_channel <= voice_q;
          midi_modified_divider <= D_W'(base_div(rem[3:0]) >> oct);
          emit_wave             <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_midi_voice_ctrl.sv
// Directed bench for midi_voice_ctrl: stimulus pushes expected strobes, a negedge monitor pops and checks them.
module tb_midi_voice_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [1:0]  ch;
  logic [15:0] dv;
  logic        cs, ws;
  logic [1:0]  wv;

  midi_voice_ctrl_if mif ();

  midi_voice_ctrl dut (
    .sys_clk                  (sys_clk),
    .sys_rst_n                (sys_rst_n),
    .midi_in                  (mif),
    .midi_modified_channel    (ch),
    .midi_modified_divider    (dv),
    .midi_chan_modified_strobe(cs),
    .wave_input               (wv),
    .midi_wave_modified_strobe(ws)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          is_wave;
    logic [1:0]  ch;
    logic [15:0] div;
    logic [1:0]  wave;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   last_acc = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n && (cs || ws)) begin
      strobe_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe chan_strobe=%0b wave_strobe=%0b required=none", cs, ws);
      end else begin
        e = sbq.pop_front();
        check("both_strobes", longint'(cs && ws), 0);
        check("strobe_kind_wave", longint'(ws), longint'(e.is_wave));
        check("channel", longint'(ch), longint'(e.ch));
        if (e.is_wave) check("wave_input", longint'(wv), longint'(e.wave));
        else           check("divider", longint'(dv), longint'(e.div));
        check("latency", longint'(cyc - e.acc + 1), longint'(e.lat));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge sys_clk);
    mif.midi_byte       = b;
    mif.midi_byte_valid = 1'b1;
    while (!mif.midi_byte_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    if (!mif.midi_byte_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout ready=0 required=1");
    end
    @(posedge sys_clk);
    #1;
    last_acc            = cyc;
    mif.midi_byte_valid = 1'b0;
  endtask

  task automatic push_exp(input bit w, input logic [1:0] c, input logic [15:0] d,
                          input logic [1:0] wave, input int lat);
    exp_t e;
    e.is_wave = w;
    e.ch      = c;
    e.div     = d;
    e.wave    = wave;
    e.acc     = last_acc;
    e.lat     = lat;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout pending=%0d required=0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, longint'(mif.midi_byte_ready), 1);
    check({tag, "_channel"}, longint'(ch), 0);
    check({tag, "_divider"}, longint'(dv), 0);
    check({tag, "_wave"}, longint'(wv), 0);
    check({tag, "_chan_strobe"}, longint'(cs), 0);
    check({tag, "_wave_strobe"}, longint'(ws), 0);
  endtask

  task automatic expect_silence(input string name);
    int s0;
    s0 = strobe_cnt;
    repeat (20) @(negedge sys_clk);
    check(name, longint'(strobe_cnt - s0), 0);
  endtask

  initial begin
    mif.midi_byte       = 8'h00;
    mif.midi_byte_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;

    // Note On A4: 69 = 5*12 + 9 -> 13636 >> 5 = 426
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    push_exp(1'b0, 2'd0, 16'd426, 2'd0, 7);
    drain();

    // Running status on channel 1: note 60 -> 716, then note 69 -> 426
    send_byte(8'h91); send_byte(8'h3C); send_byte(8'h40);
    push_exp(1'b0, 2'd1, 16'd716, 2'd0, 7);
    drain();
    send_byte(8'h45); send_byte(8'h40);
    push_exp(1'b0, 2'd1, 16'd426, 2'd0, 7);
    drain();

    // Note Off handling
    send_byte(8'h91); send_byte(8'h45); send_byte(8'h40);
    push_exp(1'b0, 2'd1, 16'd426, 2'd0, 7);
    drain();
    send_byte(8'h81); send_byte(8'h3C); send_byte(8'h00);
`ifdef MIDI_NOTE_MATCH_EN
    expect_silence("note_off_mismatch_silent");
`else
    push_exp(1'b0, 2'd1, 16'd0, 2'd0, 1);
    drain();
`endif
    send_byte(8'h91); send_byte(8'h45); send_byte(8'h00);
    push_exp(1'b0, 2'd1, 16'd0, 2'd0, 1);
    drain();

    // Program Change on channel 2
    send_byte(8'hC2); send_byte(8'h05);
    push_exp(1'b1, 2'd2, 16'd0, 2'b01, 1);
    drain();

    // Channel beyond NUM_VOICES is ignored
    send_byte(8'h94); send_byte(8'h40); send_byte(8'h40);
    expect_silence("voice_out_of_range_silent");

    // Realtime byte between data bytes is transparent
    send_byte(8'h90); send_byte(8'h45); send_byte(8'hF8); send_byte(8'h64);
    push_exp(1'b0, 2'd0, 16'd426, 2'd0, 7);
    drain();

    // Lowest and highest notes: note 0 -> 22933, note 127 = 10*12+7 -> 15306 >> 10 = 14
    send_byte(8'h90); send_byte(8'h00); send_byte(8'h10);
    push_exp(1'b0, 2'd0, 16'd22933, 2'd0, 2);
    drain();
    send_byte(8'h93); send_byte(8'h7F); send_byte(8'h01);
    push_exp(1'b0, 2'd3, 16'd14, 2'd0, 12);
    drain();

    // System common byte clears running status
    send_byte(8'hF0); send_byte(8'h45); send_byte(8'h40);
    expect_silence("sysex_clears_status_silent");

    // Reset while in CALC aborts the update
    send_byte(8'h90); send_byte(8'h7F); send_byte(8'h40);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_reset_outputs("mid_calc_reset");
    sys_rst_n = 1'b1;
    send_byte(8'h45); send_byte(8'h40);
    expect_silence("after_reset_data_silent");

    check("scoreboard_empty", longint'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
